// File: rtl/n1_dsp_divseq.sv
// Restoring 32/16 unsigned divide sequencer that borrows the DSP cell adder,
// performing one quotient bit per cycle while it owns the adder inputs.
module n1_dsp_divseq (
    input  logic        clk_i,
    input  logic        async_rst_i,
    input  logic        alu2div_req_i,
    input  logic        alu2div_abort_i,
    input  logic [31:0] alu2div_dividend_i,
    input  logic [15:0] alu2div_divisor_i,
    output logic        div2alu_ack_o,
    output logic        div2alu_busy_o,
    output logic [15:0] div2alu_quot_o,
    output logic [15:0] div2alu_rem_o,
    output logic        div2alu_dz_o,
    output logic        div2alu_ovf_o,
    output logic        div2dsp_sel_o,
    output logic        div2dsp_sub_add_b_o,
    output logic [15:0] div2dsp_add_op0_o,
    output logic [15:0] div2dsp_add_op1_o,
    input  logic [31:0] dsp2div_add_res_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CHK  = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] d_q;
    logic [15:0] r_q;
    logic [15:0] q_q;
    logic [15:0] quot_q;
    logic [15:0] rem_q;
    logic        dz_q;
    logic        ovf_q;

    logic [16:0] trial;
    logic        borrow;
    logic        step_ok;
    logic [15:0] r_step;
    logic [15:0] q_step;
    logic        unused_res;

    // Only the 16-bit difference and its borrow matter to the division.
    assign unused_res = ^dsp2div_add_res_i[31:17];

    assign trial   = {r_q, q_q[15]};
    assign borrow  = dsp2div_add_res_i[16];
    // A set trial bit 16 means the trial value already exceeds any divisor.
    assign step_ok = trial[16] | ~borrow;
    assign r_step  = step_ok ? dsp2div_add_res_i[15:0] : trial[15:0];
    assign q_step  = {q_q[14:0], step_ok};

    always_comb begin
        div2dsp_sel_o       = 1'b0;
        div2dsp_sub_add_b_o = 1'b0;
        div2dsp_add_op0_o   = 16'h0000;
        div2dsp_add_op1_o   = 16'h0000;
        case (state_q)
            S_CHK: begin
                div2dsp_sel_o       = 1'b1;
                div2dsp_sub_add_b_o = 1'b1;
                div2dsp_add_op0_o   = d_q;
                div2dsp_add_op1_o   = r_q;
            end
            S_ITER: begin
                div2dsp_sel_o       = 1'b1;
                div2dsp_sub_add_b_o = 1'b1;
                div2dsp_add_op0_o   = d_q;
                div2dsp_add_op1_o   = trial[15:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            d_q     <= 16'h0000;
            r_q     <= 16'h0000;
            q_q     <= 16'h0000;
            quot_q  <= 16'h0000;
            rem_q   <= 16'h0000;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (alu2div_req_i) begin
                        d_q   <= alu2div_divisor_i;
                        r_q   <= alu2div_dividend_i[31:16];
                        q_q   <= alu2div_dividend_i[15:0];
                        dz_q  <= 1'b0;
                        ovf_q <= 1'b0;
                        if (alu2div_divisor_i == 16'h0000) begin
                            dz_q    <= 1'b1;
                            quot_q  <= 16'hFFFF;
                            rem_q   <= alu2div_dividend_i[15:0];
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (alu2div_abort_i) begin
                        state_q <= S_IDLE;
                    end else if (!borrow) begin
                        // Upper half >= divisor: quotient cannot fit in 16 bits.
                        ovf_q   <= 1'b1;
                        quot_q  <= 16'hFFFF;
                        rem_q   <= r_q;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= 4'd0;
                        state_q <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (alu2div_abort_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        r_q <= r_step;
                        q_q <= q_step;
                        if (cnt_q == 4'd15) begin
                            quot_q  <= q_step;
                            rem_q   <= r_step;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign div2alu_ack_o  = (state_q == S_DONE);
    assign div2alu_busy_o = (state_q != S_IDLE);
    assign div2alu_quot_o = quot_q;
    assign div2alu_rem_o  = rem_q;
    assign div2alu_dz_o   = dz_q;
    assign div2alu_ovf_o  = ovf_q;

endmodule

// File: tb/tb_n1_dsp_divseq.sv
// Self-checking bench for n1_dsp_divseq: directed scenarios plus random operands
// compared against a plain-arithmetic division model.
module tb_n1_dsp_divseq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        abort;
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic        ack, busy, dz, ovf, sel, sub;
    logic [15:0] quot, rem, op0, op1;
    logic [31:0] dsp_res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Combinational DSP adder: bit 16 of a zero-extended subtraction is the borrow.
    assign dsp_res = sub ? ({16'h0000, op1} - {16'h0000, op0}) : ({16'h0000, op1} + {16'h0000, op0});

    n1_dsp_divseq dut (
        .clk_i               (clk),
        .async_rst_i         (rst),
        .alu2div_req_i       (req),
        .alu2div_abort_i     (abort),
        .alu2div_dividend_i  (dvd),
        .alu2div_divisor_i   (dvs),
        .div2alu_ack_o       (ack),
        .div2alu_busy_o      (busy),
        .div2alu_quot_o      (quot),
        .div2alu_rem_o       (rem),
        .div2alu_dz_o        (dz),
        .div2alu_ovf_o       (ovf),
        .div2dsp_sel_o       (sel),
        .div2dsp_sub_add_b_o (sub),
        .div2dsp_add_op0_o   (op0),
        .div2dsp_add_op1_o   (op1),
        .dsp2div_add_res_i   (dsp_res)
    );

    // Reference: what the divider must report for a/b, and when ack appears.
    function automatic void ref_div(input logic [31:0] a, input logic [15:0] b,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output logic edz, output logic eovf, output int lat);
        longint unsigned qa;
        edz = 1'b0; eovf = 1'b0;
        if (b == 16'h0000) begin
            edz = 1'b1; q = 16'hFFFF; r = a[15:0]; lat = 1;
        end else if (a[31:16] >= b) begin
            eovf = 1'b1; q = 16'hFFFF; r = a[31:16]; lat = 2;
        end else begin
            qa = longint'(a) / longint'(b);
            q = qa[15:0];
            qa = longint'(a) % longint'(b);
            r = qa[15:0];
            lat = 18;
        end
    endfunction

    // Issue one request from a negedge and observe it until ack (bounded).
    task automatic run_div(input logic [31:0] a, input logic [15:0] b, input bit hold,
                           input logic [31:0] na, input logic [15:0] nb,
                           output int waits, output int ack_cyc, output int sel_first,
                           output int sel_last, output logic [15:0] q, output logic [15:0] r,
                           output logic odz, output logic oovf);
        int c;
        dvd = a; dvs = b; req = 1'b1;
        waits = 0; ack_cyc = -1; sel_first = -1; sel_last = -1;
        q = 16'h0000; r = 16'h0000; odz = 1'b0; oovf = 1'b0;
        do begin
            @(posedge clk); @(negedge clk); waits++;
        end while (!busy && waits < 4);
        c = 1;
        forever begin
            if (sel) begin
                if (sel_first < 0) sel_first = c;
                sel_last = c;
            end
            if (ack) begin
                ack_cyc = c; q = quot; r = rem; odz = dz; oovf = ovf;
                break;
            end
            if (c >= 40) break;
            @(negedge clk); c++;
        end
        if (hold) begin dvd = na; dvs = nb; end
        else req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; abort = 1'b0; dvd = 32'h0; dvs = 16'h0;
        #1;
        checks++; if ({ack, busy, sel, sub, dz, ovf} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b expected 000000", {ack, busy, sel, sub, dz, ovf}); end
        checks++; if ({op0, op1, quot, rem} !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {op0, op1, quot, rem}); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("reset: flags=%b quot=%h rem=%h", {ack, busy, sel, dz, ovf}, quot, rem);
    endtask

    task automatic test_basic();
        int w, ac, sf, sl; logic [15:0] q, r; logic odz, oovf;
        run_div(32'h00000064, 16'h0007, 1'b0, 32'h0, 16'h0, w, ac, sf, sl, q, r, odz, oovf);
        $display("basic: 100/7 -> q=%h r=%h dz=%b ovf=%b ack_cycle=%0d sel=%0d..%0d", q, r, odz, oovf, ac, sf, sl);
        checks++; if (q !== 16'h000E) begin errors++; $display("FAIL basic_quot: got %h expected 000e", q); end
        checks++; if (r !== 16'h0002) begin errors++; $display("FAIL basic_rem: got %h expected 0002", r); end
        checks++; if ({odz, oovf} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b expected 00", {odz, oovf}); end
        checks++; if (ac !== 18) begin errors++; $display("FAIL basic_latency: got %0d expected 18", ac); end
        checks++; if (sf !== 1 || sl !== 17) begin errors++; $display("FAIL basic_sel_window: got %0d..%0d expected 1..17", sf, sl); end
        @(negedge clk);
        checks++; if (ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_ack_pulse: got ack=%b busy=%b expected 0 0", ack, busy); end
        repeat (3) @(negedge clk);
        checks++; if (quot !== 16'h000E || rem !== 16'h0002) begin errors++; $display("FAIL basic_hold: got %h/%h expected 000e/0002", quot, rem); end
    endtask

    task automatic test_max();
        int w, ac, sf, sl; logic [15:0] q, r; logic odz, oovf;
        run_div(32'hFFFE0001, 16'hFFFF, 1'b0, 32'h0, 16'h0, w, ac, sf, sl, q, r, odz, oovf);
        $display("max: fffe0001/ffff -> q=%h r=%h ovf=%b ack_cycle=%0d", q, r, oovf, ac);
        checks++; if (q !== 16'hFFFF || r !== 16'h0000) begin errors++; $display("FAIL max_result: got %h/%h expected ffff/0000", q, r); end
        checks++; if (oovf !== 1'b0 || ac !== 18) begin errors++; $display("FAIL max_ovf_lat: got ovf=%b lat=%0d expected 0 18", oovf, ac); end
        @(negedge clk);
    endtask

    task automatic test_dz_ovf();
        int w, ac, sf, sl; logic [15:0] q, r; logic odz, oovf;
        run_div(32'h12345678, 16'h0000, 1'b0, 32'h0, 16'h0, w, ac, sf, sl, q, r, odz, oovf);
        $display("dz: 12345678/0 -> q=%h r=%h dz=%b ack_cycle=%0d sel_first=%0d", q, r, odz, ac, sf);
        checks++; if (odz !== 1'b1 || oovf !== 1'b0) begin errors++; $display("FAIL dz_flags: got dz=%b ovf=%b expected 1 0", odz, oovf); end
        checks++; if (q !== 16'hFFFF || r !== 16'h5678) begin errors++; $display("FAIL dz_result: got %h/%h expected ffff/5678", q, r); end
        checks++; if (ac !== 1 || sf !== -1) begin errors++; $display("FAIL dz_timing: got lat=%0d sel_first=%0d expected 1 -1", ac, sf); end
        @(negedge clk);
        run_div(32'h00070000, 16'h0007, 1'b0, 32'h0, 16'h0, w, ac, sf, sl, q, r, odz, oovf);
        $display("ovf: 00070000/7 -> q=%h r=%h ovf=%b ack_cycle=%0d", q, r, oovf, ac);
        checks++; if (oovf !== 1'b1 || odz !== 1'b0) begin errors++; $display("FAIL ovf_flags: got ovf=%b dz=%b expected 1 0", oovf, odz); end
        checks++; if (q !== 16'hFFFF || r !== 16'h0007) begin errors++; $display("FAIL ovf_result: got %h/%h expected ffff/0007", q, r); end
        checks++; if (ac !== 2) begin errors++; $display("FAIL ovf_latency: got %0d expected 2", ac); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int w, ac, sf, sl, acks; logic [15:0] q, r; logic odz, oovf;
        run_div(32'h00000064, 16'h0007, 1'b0, 32'h0, 16'h0, w, ac, sf, sl, q, r, odz, oovf);
        @(negedge clk);
        dvd = 32'h00001000; dvs = 16'h0003; req = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 9; c++) @(negedge clk);
        abort = 1'b1; req = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        $display("abort: busy=%b sel=%b ack=%b quot=%h rem=%h", busy, sel, ack, quot, rem);
        checks++; if (busy !== 1'b0 || sel !== 1'b0 || ack !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b sel=%b ack=%b expected 0 0 0", busy, sel, ack); end
        checks++; if (quot !== 16'h000E || rem !== 16'h0002) begin errors++; $display("FAIL abort_stale: got %h/%h expected 000e/0002", quot, rem); end
        acks = 0;
        repeat (20) begin @(negedge clk); if (ack) acks++; end
        checks++; if (acks !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks expected 0", acks); end
        run_div(32'h00000064, 16'h0007, 1'b0, 32'h0, 16'h0, w, ac, sf, sl, q, r, odz, oovf);
        $display("abort_restart: 100/7 -> q=%h r=%h ack_cycle=%0d", q, r, ac);
        checks++; if (q !== 16'h000E || r !== 16'h0002 || ac !== 18) begin errors++; $display("FAIL abort_restart: got %h/%h lat=%0d expected 000e/0002 18", q, r, ac); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        dvd = 32'h00001000; dvs = 16'h0003; req = 1'b1;
        @(posedge clk);
        repeat (6) @(negedge clk);
        checks++; if (sel !== 1'b1) begin errors++; $display("FAIL midrst_running: got sel=%b expected 1", sel); end
        rst = 1'b1;
        #1;
        $display("reset_mid: busy=%b sel=%b op0=%h op1=%h quot=%h rem=%h", busy, sel, op0, op1, quot, rem);
        checks++; if ({ack, busy, sel, sub, dz, ovf} !== 6'b0) begin errors++; $display("FAIL midrst_flags: got %b expected 000000", {ack, busy, sel, sub, dz, ovf}); end
        checks++; if ({op0, op1, quot, rem} !== 64'h0) begin errors++; $display("FAIL midrst_data: got %h expected 0", {op0, op1, quot, rem}); end
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int w, ac, sf, sl; logic [15:0] q, r; logic odz, oovf;
        run_div(32'd1000, 16'd10, 1'b1, 32'd65535, 16'd256, w, ac, sf, sl, q, r, odz, oovf);
        $display("b2b first: 1000/10 -> q=%0d r=%0d ack_cycle=%0d", q, r, ac);
        checks++; if (q !== 16'd100 || r !== 16'd0 || ac !== 18) begin errors++; $display("FAIL b2b_first: got %0d/%0d lat=%0d expected 100/0 18", q, r, ac); end
        run_div(32'd65535, 16'd256, 1'b0, 32'h0, 16'h0, w, ac, sf, sl, q, r, odz, oovf);
        $display("b2b second: 65535/256 -> q=%0d r=%0d edges_to_accept=%0d ack_cycle=%0d", q, r, w, ac);
        checks++; if (w !== 2) begin errors++; $display("FAIL b2b_accept: got %0d edges expected 2", w); end
        checks++; if (q !== 16'd255 || r !== 16'd255 || ac !== 18) begin errors++; $display("FAIL b2b_second: got %0d/%0d lat=%0d expected 255/255 18", q, r, ac); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int w, ac, sf, sl, elat, esf, esl; logic [15:0] q, r, eq, er; logic odz, oovf, edz, eovf;
        logic [31:0] a; logic [15:0] b; int mode;
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 9));
            a = $urandom;
            b = 16'($urandom_range(1, 65535));
            if (mode == 0) b = 16'h0000;
            else if (mode < 8) a[31:16] = 16'($urandom % b);
            ref_div(a, b, eq, er, edz, eovf, elat);
            esf = edz ? -1 : 1;
            esl = edz ? -1 : (eovf ? 1 : 17);
            run_div(a, b, 1'b0, 32'h0, 16'h0, w, ac, sf, sl, q, r, odz, oovf);
            $display("random %0d: %h/%h -> q=%h r=%h dz=%b ovf=%b lat=%0d (model %h/%h %b%b %0d)", i, a, b, q, r, odz, oovf, ac, eq, er, edz, eovf, elat);
            checks++; if ({q, r, odz, oovf} !== {eq, er, edz, eovf}) begin errors++; $display("FAIL rand_result %0d: got %h/%h %b%b expected %h/%h %b%b", i, q, r, odz, oovf, eq, er, edz, eovf); end
            checks++; if (ac !== elat || sf !== esf || sl !== esl) begin errors++; $display("FAIL rand_timing %0d: got lat=%0d sel=%0d..%0d expected %0d %0d..%0d", i, ac, sf, sl, elat, esf, esl); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_dz_ovf();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
